// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared encodings for the multi-layer block scheduler.
//   - FSM state constants (IDLE / ISSUE / WAIT)
//   - block type encodings (FF=0, FB=1, BF=2, BB=3)
//   - config field select encodings for the layer table
//   - nextPhase(): per-layer phase order FF -> BF -> BB -> FB -> FF
// ---------------------------------------------------------------------------
package sched_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        BT_FF = 2'd0,
        BT_FB = 2'd1,
        BT_BF = 2'd2,
        BT_BB = 2'd3
    } blockType_e;

    typedef enum logic [1:0] {
        SEL_FWD_LEN = 2'd0,
        SEL_BWD_LEN = 2'd1,
        SEL_FWD_BP  = 2'd2,
        SEL_BWD_BP  = 2'd3
    } cfgSel_e;

    // The phase order is not the numeric order of the encodings, so the
    // successor is looked up explicitly.
    function automatic blockType_e nextPhase(input blockType_e p);
        blockType_e n;
        case (p)
            BT_FF:   n = BT_BF;
            BT_BF:   n = BT_BB;
            BT_BB:   n = BT_FB;
            default: n = BT_FF;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/block_geometry_calc.sv
// ---------------------------------------------------------------------------
// block_geometry_calc
// Combinational descriptor arithmetic for one phase of one layer.
// Breakpoints are clamped to their lengths first, so every subtraction
// below is non-negative.
// Ports:
//   i_fwdLen, i_bwdLen   layer forward / backward lengths
//   i_fwdBp,  i_bwdBp    layer forward / backward breakpoints (unclamped)
//   i_blockType          phase being described
//   o_b0Start/o_b0Length block 0 geometry
//   o_b1Start/o_b1Length block 1 geometry
// ---------------------------------------------------------------------------
module block_geometry_calc
    import sched_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic [ADDR_W-1:0] i_fwdLen,
    input  logic [ADDR_W-1:0] i_bwdLen,
    input  logic [ADDR_W-1:0] i_fwdBp,
    input  logic [ADDR_W-1:0] i_bwdBp,
    input  blockType_e        i_blockType,
    output logic [ADDR_W-1:0] o_b0Start,
    output logic [ADDR_W-1:0] o_b0Length,
    output logic [ADDR_W-1:0] o_b1Start,
    output logic [ADDR_W-1:0] o_b1Length
);

    logic [ADDR_W-1:0] w_f;
    logic [ADDR_W-1:0] w_b;
    logic [ADDR_W-1:0] w_fwdRem;
    logic [ADDR_W-1:0] w_bwdRem;

    assign w_f      = (i_fwdBp > i_fwdLen) ? i_fwdLen : i_fwdBp;
    assign w_b      = (i_bwdBp > i_bwdLen) ? i_bwdLen : i_bwdBp;
    assign w_fwdRem = i_fwdLen - w_f;
    assign w_bwdRem = i_bwdLen - w_b;

    always_comb begin
        o_b0Start  = '0;
        o_b0Length = '0;
        o_b1Start  = '0;
        o_b1Length = '0;
        case (i_blockType)
            BT_FF: begin
                o_b0Start  = w_f;
                o_b0Length = w_fwdRem;
                o_b1Length = w_fwdRem;
            end
            BT_BF: begin
                o_b0Length = w_b;
                o_b1Start  = w_fwdRem;
                o_b1Length = w_f;
            end
            BT_BB: begin
                o_b0Start  = w_b;
                o_b0Length = w_bwdRem;
                o_b1Length = w_bwdRem;
            end
            default: begin
                o_b0Length = w_f;
                o_b1Start  = w_bwdRem;
                o_b1Length = w_b;
            end
        endcase
    end

endmodule

// File: rtl/multi_layer_block_scheduler.sv
// ---------------------------------------------------------------------------
// multi_layer_block_scheduler
// Walks num_iters x num_layers x {FF,BF,BB,FB} and issues one registered
// block-pair descriptor per phase, waiting for the consumer to accept it
// and then for the blocks to finish before moving on.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   cfg_we_i/cfg_layer_i/cfg_sel_i/cfg_data_i  layer table write port
//   start_i, num_layers_i, num_iters_i run request
//   sched_valid_o / sched_ready_i     descriptor handshake
//   block{0,1}_{start,length}_o, block_type_o, layer_o, last_o  descriptor
//   block_finish_valid_i              issued pair completed
//   busy_o, done_o, err_o             run status, completion pulse, sticky error
// ---------------------------------------------------------------------------
module multi_layer_block_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int ADDR_W     = 32,
    parameter int ITER_W     = 16,
    localparam int LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
)(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cfg_we_i,
    input  logic [LAYER_W-1:0] cfg_layer_i,
    input  logic [1:0]         cfg_sel_i,
    input  logic [ADDR_W-1:0]  cfg_data_i,
    input  logic               start_i,
    input  logic [LAYER_W:0]   num_layers_i,
    input  logic [ITER_W-1:0]  num_iters_i,
    output logic               sched_valid_o,
    input  logic               sched_ready_i,
    output logic [ADDR_W-1:0]  block0_start_o,
    output logic [ADDR_W-1:0]  block0_length_o,
    output logic [ADDR_W-1:0]  block1_start_o,
    output logic [ADDR_W-1:0]  block1_length_o,
    output logic [1:0]         block_type_o,
    output logic [LAYER_W-1:0] layer_o,
    output logic               last_o,
    input  logic               block_finish_valid_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam logic [LAYER_W:0] MAX_LAYERS = (LAYER_W+1)'(NUM_LAYERS);

    logic [1:0]         r_state;
    blockType_e         r_phase;
    logic [LAYER_W-1:0] r_layer;
    logic [ITER_W-1:0]  r_iter;
    logic [LAYER_W:0]   r_numLayers;
    logic [ITER_W-1:0]  r_numIters;
    logic [ADDR_W-1:0]  r_fwdLen [NUM_LAYERS];
    logic [ADDR_W-1:0]  r_bwdLen [NUM_LAYERS];
    logic [ADDR_W-1:0]  r_fwdBp  [NUM_LAYERS];
    logic [ADDR_W-1:0]  r_bwdBp  [NUM_LAYERS];
    logic [ADDR_W-1:0]  r_b0Start;
    logic [ADDR_W-1:0]  r_b0Length;
    logic [ADDR_W-1:0]  r_b1Start;
    logic [ADDR_W-1:0]  r_b1Length;
    logic               r_last;
    logic               r_done;
    logic               r_err;

    logic               w_startOk;
    logic               w_cfgInRange;
    logic               w_load;
    logic               w_lastLayer;
    blockType_e         w_tgtPhase;
    logic [LAYER_W-1:0] w_tgtLayer;
    logic [ITER_W-1:0]  w_tgtIter;
    logic               w_tgtLast;
    logic [ADDR_W-1:0]  w_b0Start;
    logic [ADDR_W-1:0]  w_b0Length;
    logic [ADDR_W-1:0]  w_b1Start;
    logic [ADDR_W-1:0]  w_b1Length;

    assign w_startOk    = start_i && (num_layers_i != '0) && (num_iters_i != '0);
    assign w_cfgInRange = int'(cfg_layer_i) < NUM_LAYERS;
    assign w_load       = ((r_state == ST_IDLE) && w_startOk) ||
                          ((r_state == ST_WAIT) && block_finish_valid_i && !r_last);

    // Indices of the descriptor that will be loaded next: the first one of a
    // run when idle, otherwise the successor of the one currently held.
    always_comb begin
        w_lastLayer = ({1'b0, r_layer} == (r_numLayers - (LAYER_W+1)'(1)));
        w_tgtPhase  = nextPhase(r_phase);
        w_tgtLayer  = r_layer;
        w_tgtIter   = r_iter;
        if (r_state == ST_IDLE) begin
            w_tgtPhase = BT_FF;
            w_tgtLayer = '0;
            w_tgtIter  = '0;
        end else if (r_phase == BT_FB) begin
            if (w_lastLayer) begin
                w_tgtLayer = '0;
                w_tgtIter  = r_iter + ITER_W'(1);
            end else begin
                w_tgtLayer = r_layer + LAYER_W'(1);
            end
        end
        w_tgtLast = (w_tgtPhase == BT_FB) &&
                    ({1'b0, w_tgtLayer} == (r_numLayers - (LAYER_W+1)'(1))) &&
                    (w_tgtIter == (r_numIters - ITER_W'(1)));
    end

    block_geometry_calc #(
        .ADDR_W (ADDR_W)
    ) u_geometry (
        .i_fwdLen    (r_fwdLen[w_tgtLayer]),
        .i_bwdLen    (r_bwdLen[w_tgtLayer]),
        .i_fwdBp     (r_fwdBp[w_tgtLayer]),
        .i_bwdBp     (r_bwdBp[w_tgtLayer]),
        .i_blockType (w_tgtPhase),
        .o_b0Start   (w_b0Start),
        .o_b0Length  (w_b0Length),
        .o_b1Start   (w_b1Start),
        .o_b1Length  (w_b1Length)
    );

    // Layer table: writable in any state; out-of-range slots are dropped
    // (the error flag is raised by the control block).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_fwdLen[i] <= '0;
                r_bwdLen[i] <= '0;
                r_fwdBp[i]  <= '0;
                r_bwdBp[i]  <= '0;
            end
        end else if (cfg_we_i && w_cfgInRange) begin
            case (cfg_sel_i)
                SEL_FWD_LEN: r_fwdLen[cfg_layer_i] <= cfg_data_i;
                SEL_BWD_LEN: r_bwdLen[cfg_layer_i] <= cfg_data_i;
                SEL_FWD_BP:  r_fwdBp[cfg_layer_i]  <= cfg_data_i;
                default:     r_bwdBp[cfg_layer_i]  <= cfg_data_i;
            endcase
        end
    end

    // Control FSM, descriptor registers and status flags. Protocol
    // violations never change the sequence, they only set the sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_phase     <= BT_FF;
            r_layer     <= '0;
            r_iter      <= '0;
            r_numLayers <= '0;
            r_numIters  <= '0;
            r_b0Start   <= '0;
            r_b0Length  <= '0;
            r_b1Start   <= '0;
            r_b1Length  <= '0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (cfg_we_i && !w_cfgInRange) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (block_finish_valid_i) begin
                        r_err <= 1'b1;
                    end
                    if (start_i && !w_startOk) begin
                        r_done <= 1'b1;
                    end else if (w_startOk) begin
                        r_state     <= ST_ISSUE;
                        r_numLayers <= (num_layers_i > MAX_LAYERS) ? MAX_LAYERS : num_layers_i;
                        r_numIters  <= num_iters_i;
                    end
                end
                ST_ISSUE: begin
                    if (block_finish_valid_i || start_i) begin
                        r_err <= 1'b1;
                    end
                    if (sched_ready_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (start_i) begin
                        r_err <= 1'b1;
                    end
                    if (block_finish_valid_i) begin
                        if (r_last) begin
                            r_state <= ST_IDLE;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_load) begin
                r_phase    <= w_tgtPhase;
                r_layer    <= w_tgtLayer;
                r_iter     <= w_tgtIter;
                r_b0Start  <= w_b0Start;
                r_b0Length <= w_b0Length;
                r_b1Start  <= w_b1Start;
                r_b1Length <= w_b1Length;
                r_last     <= w_tgtLast;
            end
        end
    end

    assign sched_valid_o   = (r_state == ST_ISSUE);
    assign busy_o          = (r_state != ST_IDLE);
    assign block0_start_o  = r_b0Start;
    assign block0_length_o = r_b0Length;
    assign block1_start_o  = r_b1Start;
    assign block1_length_o = r_b1Length;
    assign block_type_o    = r_phase;
    assign layer_o         = r_layer;
    assign last_o          = r_last;
    assign done_o          = r_done;
    assign err_o           = r_err;

endmodule
